// File: rtl/vga_timing_gen.sv
// vga_timing_gen: video timing generator (syncs, DE, pixel coordinates,
// line/frame strobes) advancing one pixel per CLK cycle with EN high.
// Optional colour-bar test pattern on RGB: define VGA_TIMING_GEN_TPG_EN.
// Without it RGB is tied to zero.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned CTR_WIDTH = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    output logic                 HSYNC,
    output logic                 VSYNC,
    output logic                 DE,
    output logic [CTR_WIDTH-1:0] X,
    output logic [CTR_WIDTH-1:0] Y,
    output logic                 LINE_START,
    output logic                 FRAME_START,
    output logic [23:0]          RGB
);

    // Region states shared by the horizontal and vertical FSMs
    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FRONT  = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BACK   = 2'd3;

    // Region order: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE
    function automatic logic [1:0] next_state(input logic [1:0] st);
        case (st)
            ST_ACTIVE: return ST_FRONT;
            ST_FRONT:  return ST_SYNC;
            ST_SYNC:   return ST_BACK;
            default:   return ST_ACTIVE;
        endcase
    endfunction

    // Horizontal region length minus one (residual count loaded on entry)
    function automatic logic [CTR_WIDTH-1:0] h_len_m1(input logic [1:0] st);
        case (st)
            ST_ACTIVE: return CTR_WIDTH'(H_ACTIVE - 1);
            ST_FRONT:  return CTR_WIDTH'(H_FP - 1);
            ST_SYNC:   return CTR_WIDTH'(H_SYNC - 1);
            default:   return CTR_WIDTH'(H_BP - 1);
        endcase
    endfunction

    // Vertical region length minus one, in lines
    function automatic logic [CTR_WIDTH-1:0] v_len_m1(input logic [1:0] st);
        case (st)
            ST_ACTIVE: return CTR_WIDTH'(V_ACTIVE - 1);
            ST_FRONT:  return CTR_WIDTH'(V_FP - 1);
            ST_SYNC:   return CTR_WIDTH'(V_SYNC - 1);
            default:   return CTR_WIDTH'(V_BP - 1);
        endcase
    endfunction

    logic [1:0]           h_state_q, h_state_d;
    logic [CTR_WIDTH-1:0] h_rem_q, h_rem_d;
    logic [CTR_WIDTH-1:0] h_cnt_q, h_cnt_d;
    logic                 h_wrap_c;

    logic [1:0]           v_state_q, v_state_d;
    logic [CTR_WIDTH-1:0] v_rem_q, v_rem_d;
    logic [CTR_WIDTH-1:0] v_cnt_q, v_cnt_d;

    logic                 active_c;

    logic [CTR_WIDTH-1:0] x_q, x_d;
    logic [CTR_WIDTH-1:0] y_q, y_d;
    logic                 de_q, de_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 line_start_q, line_start_d;
    logic                 frame_start_q, frame_start_d;

    // Horizontal next state: step residual count, change region on expiry
    always_comb begin
        h_state_d = h_state_q;
        h_rem_d   = h_rem_q;
        h_cnt_d   = h_cnt_q;
        h_wrap_c  = 1'b0;
        if (EN) begin
            if (h_rem_q == '0) begin
                h_state_d = next_state(h_state_q);
                h_rem_d   = h_len_m1(next_state(h_state_q));
            end else begin
                h_rem_d = h_rem_q - CTR_WIDTH'(1);
            end
            if ((h_state_q == ST_BACK) && (h_rem_q == '0)) begin
                h_wrap_c = 1'b1;
                h_cnt_d  = '0;
            end else begin
                h_cnt_d = h_cnt_q + CTR_WIDTH'(1);
            end
        end
    end

    // Horizontal state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            h_state_q <= ST_ACTIVE;
            h_rem_q   <= CTR_WIDTH'(H_ACTIVE - 1);
            h_cnt_q   <= '0;
        end else begin
            h_state_q <= h_state_d;
            h_rem_q   <= h_rem_d;
            h_cnt_q   <= h_cnt_d;
        end
    end

    // Vertical next state: only moves on the cycle the line wraps
    always_comb begin
        v_state_d = v_state_q;
        v_rem_d   = v_rem_q;
        v_cnt_d   = v_cnt_q;
        if (h_wrap_c) begin
            if (v_rem_q == '0) begin
                v_state_d = next_state(v_state_q);
                v_rem_d   = v_len_m1(next_state(v_state_q));
            end else begin
                v_rem_d = v_rem_q - CTR_WIDTH'(1);
            end
            if ((v_state_q == ST_BACK) && (v_rem_q == '0)) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + CTR_WIDTH'(1);
            end
        end
    end

    // Vertical state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            v_state_q <= ST_ACTIVE;
            v_rem_q   <= CTR_WIDTH'(V_ACTIVE - 1);
            v_cnt_q   <= '0;
        end else begin
            v_state_q <= v_state_d;
            v_rem_q   <= v_rem_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    assign active_c = (h_state_q == ST_ACTIVE) && (v_state_q == ST_ACTIVE);

    // Output decode of the current (h,v), loaded on EN cycles; strobes self-clear
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (EN) begin
            x_d           = h_cnt_q;
            y_d           = v_cnt_q;
            de_d          = active_c;
            hsync_d       = (h_state_q == ST_SYNC) ? HS_POL : ~HS_POL;
            vsync_d       = (v_state_q == ST_SYNC) ? VS_POL : ~VS_POL;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    // Output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign X           = x_q;
    assign Y           = y_q;
    assign DE          = de_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

`ifdef VGA_TIMING_GEN_TPG_EN
    // Bar width in pixels; kept at least one so tiny active widths still work
    localparam int unsigned BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

    // Colour-bar palette: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    logic [CTR_WIDTH-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]           bar_idx_q, bar_idx_d;
    logic [23:0]          rgb_q, rgb_d;

    // Bar position tracks h without a divider; restarts at every line wrap
    always_comb begin
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        rgb_d     = rgb_q;
        if (EN) begin
            rgb_d = active_c ? bar_colour(bar_idx_q) : 24'h0;
            if (h_wrap_c) begin
                bar_pix_d = '0;
                bar_idx_d = 3'd0;
            end else if (h_state_q == ST_ACTIVE) begin
                if (bar_pix_q == CTR_WIDTH'(BAR_W - 1)) begin
                    bar_pix_d = '0;
                    if (bar_idx_q != 3'd7) begin
                        bar_idx_d = bar_idx_q + 3'd1;
                    end
                end else begin
                    bar_pix_d = bar_pix_q + CTR_WIDTH'(1);
                end
            end
        end
    end

    // Test-pattern registers, aligned with the timing outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            bar_pix_q <= '0;
            bar_idx_q <= 3'd0;
            rgb_q     <= 24'h0;
        end else begin
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            rgb_q     <= rgb_d;
        end
    end

    assign RGB = rgb_q;
`else
    assign RGB = 24'h0;
`endif

endmodule
